// File: rtl/int_to_float_pipe.sv
// int_to_float_pipe: 3-stage integer to IEEE-754 binary32 converter, round-to-nearest-even.
// Optional macro ITOF_INEXACT_FLAG_EN adds m_axis_result_tuser carrying the inexact flag.
module int_to_float_pipe #(
    parameter int IN_WIDTH = 32,
    parameter int SIGNED   = 1
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [IN_WIDTH-1:0] s_axis_a_tdata,
    input  logic                s_axis_a_tvalid,
    output logic                s_axis_a_tready,
    output logic [31:0]         m_axis_result_tdata,
    output logic                m_axis_result_tvalid,
    input  logic                m_axis_result_tready
`ifdef ITOF_INEXACT_FLAG_EN
    ,
    output logic                m_axis_result_tuser
`endif
);

    localparam int PW = $clog2(IN_WIDTH);
    localparam int FW = IN_WIDTH - 1;
    localparam int EW = FW + 25;
    localparam logic [PW-1:0] TOP = PW'(IN_WIDTH - 1);

    // Handshake: a beat moves on a port at a rising edge where tvalid && tready.
    // All three stages shift together whenever the output register is empty or drained.
    logic en;

    logic                s1_valid_q, s1_valid_d;
    logic                s1_sign_q,  s1_sign_d;
    logic [IN_WIDTH-1:0] s1_mag_q,   s1_mag_d;

    logic                s2_valid_q, s2_valid_d;
    logic                s2_sign_q,  s2_sign_d;
    logic                s2_zero_q,  s2_zero_d;
    logic [PW-1:0]       s2_p_q,     s2_p_d;
    logic [FW-1:0]       s2_frac_q,  s2_frac_d;

    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q,  out_data_d;

    logic [PW-1:0]       lod_p;
    logic [IN_WIDTH-1:0] norm;
    logic [EW-1:0]       ext;
    logic [22:0]         mant;
    logic                guard;
    logic                sticky;
    logic                round_inc;
    logic [23:0]         mant_rnd;
    logic [7:0]          exp_field;
    logic [31:0]         packed_res;

    assign en                   = !out_valid_q || m_axis_result_tready;
    assign s_axis_a_tready      = en && !areset;
    assign m_axis_result_tvalid = out_valid_q;
    assign m_axis_result_tdata  = out_data_q;

    // S1: sign and magnitude; the most negative value negates to 2^(IN_WIDTH-1).
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        if (en) begin
            s1_valid_d = s_axis_a_tvalid;
            s1_sign_d  = (SIGNED != 0) && s_axis_a_tdata[IN_WIDTH-1];
            s1_mag_d   = s1_sign_d ? (~s_axis_a_tdata + {{(IN_WIDTH-1){1'b0}}, 1'b1})
                                   : s_axis_a_tdata;
        end
    end

    // S2: leading-one detect and left normalisation.
    always_comb begin
        lod_p = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (s1_mag_q[i]) begin
                lod_p = i[PW-1:0];
            end
        end
        norm = s1_mag_q << (TOP - lod_p);
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_p_d     = s2_p_q;
        s2_frac_d  = s2_frac_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_zero_d  = !norm[IN_WIDTH-1];
            s2_p_d     = lod_p;
            s2_frac_d  = norm[FW-1:0];
        end
    end

    // S3: the fraction below the leading one, padded so narrow inputs still yield 23 bits.
    always_comb begin
        ext       = {s2_frac_q, 25'd0};
        mant      = ext[EW-1 -: 23];
        guard     = ext[EW-24];
        sticky    = |ext[EW-25:0];
        round_inc = guard && (sticky || mant[0]);
        mant_rnd  = {1'b0, mant} + {23'd0, round_inc};
        exp_field = 8'd127 + {{(8-PW){1'b0}}, s2_p_q} + {7'd0, mant_rnd[23]};
        if (s2_zero_q) begin
            packed_res = 32'd0;
        end else begin
            packed_res = {s2_sign_q, exp_field, mant_rnd[23] ? 23'd0 : mant_rnd[22:0]};
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (en) begin
            out_valid_d = s2_valid_q;
            out_data_d  = packed_res;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_p_q      <= '0;
            s2_frac_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_zero_q   <= s2_zero_d;
            s2_p_q      <= s2_p_d;
            s2_frac_q   <= s2_frac_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef ITOF_INEXACT_FLAG_EN
    // Inexact is judged before rounding and travels with its result through stalls.
    logic inexact;
    logic out_inexact_q, out_inexact_d;

    assign inexact             = !s2_zero_q && (guard || sticky);
    assign m_axis_result_tuser = out_inexact_q;

    always_comb begin
        out_inexact_d = out_inexact_q;
        if (en) begin
            out_inexact_d = inexact;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_inexact_q <= 1'b0;
        end else begin
            out_inexact_q <= out_inexact_d;
        end
    end
`endif

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Bench for int_to_float_pipe: signed 32-bit main instance plus unsigned 32-bit and 8-bit instances.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_int_to_float_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic areset;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_ready;

    logic [31:0] u32_data;
    logic [7:0]  u8_data;
    logic        a_valid;
    logic        u32_ready, u8_ready;
    logic [31:0] u32_res, u8_res;
    logic        u32_rvalid, u8_rvalid;
    logic        a_rready;

`ifdef ITOF_INEXACT_FLAG_EN
    logic r_user, u32_user, u8_user;
`endif

    int_to_float_pipe #(.IN_WIDTH(32), .SIGNED(1)) dut (
        .aclk                 (clk),
        .areset               (areset),
        .s_axis_a_tdata       (s_data),
        .s_axis_a_tvalid      (s_valid),
        .s_axis_a_tready      (s_ready),
        .m_axis_result_tdata  (r_data),
        .m_axis_result_tvalid (r_valid),
        .m_axis_result_tready (r_ready)
`ifdef ITOF_INEXACT_FLAG_EN
        ,
        .m_axis_result_tuser  (r_user)
`endif
    );

    int_to_float_pipe #(.IN_WIDTH(32), .SIGNED(0)) dut_u32 (
        .aclk                 (clk),
        .areset               (areset),
        .s_axis_a_tdata       (u32_data),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_a_tready      (u32_ready),
        .m_axis_result_tdata  (u32_res),
        .m_axis_result_tvalid (u32_rvalid),
        .m_axis_result_tready (a_rready)
`ifdef ITOF_INEXACT_FLAG_EN
        ,
        .m_axis_result_tuser  (u32_user)
`endif
    );

    int_to_float_pipe #(.IN_WIDTH(8), .SIGNED(0)) dut_u8 (
        .aclk                 (clk),
        .areset               (areset),
        .s_axis_a_tdata       (u8_data),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_a_tready      (u8_ready),
        .m_axis_result_tdata  (u8_res),
        .m_axis_result_tvalid (u8_rvalid),
        .m_axis_result_tready (a_rready)
`ifdef ITOF_INEXACT_FLAG_EN
        ,
        .m_axis_result_tuser  (u8_user)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];
    bit rand_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference conversion by integer division/remainder rounding; {inexact, binary32}.
    function automatic logic [32:0] ref_conv(input logic [31:0] x);
        logic        neg;
        logic        inx;
        logic [31:0] a;
        logic [63:0] m, q, rem, half;
        int          e;
        if (x == 32'd0) return 33'd0;
        neg = x[31];
        a   = neg ? (~x + 32'd1) : x;
        m   = {32'd0, a};
        e   = 31;
        while (m[e] == 1'b0) e--;
        inx = 1'b0;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            q    = m >> (e - 23);
            rem  = m - (q << (e - 23));
            half = 64'd1 << (e - 24);
            inx  = (rem != 64'd0);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q[24]) begin
                q = q >> 1;
                e++;
            end
        end
        return {inx, neg, 8'(e + 127), q[22:0]};
    endfunction

    // Scoreboard on the main instance: whatever is presented must be the oldest expected item.
    always @(negedge clk) begin
        if (!areset && r_valid) begin
            if (exp_q.size() == 0) begin
                check("stray_result", {31'd0, r_valid}, 32'd0);
            end else begin
                check("result_data", r_data, exp_q[0][31:0]);
`ifdef ITOF_INEXACT_FLAG_EN
                check("result_inexact", {31'd0, r_user}, {31'd0, exp_q[0][32]});
`endif
                if (r_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [32:0] e);
        bit done;
        done    = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Result register loads on the third rising edge counting the accepting one.
    task automatic convert_one(input logic [31:0] d, input logic [32:0] e);
        send(d, e);
        @(negedge clk);
        check("latency_edge1", {31'd0, r_valid}, 32'd0);
        @(negedge clk);
        check("latency_edge2", {31'd0, r_valid}, 32'd0);
        @(negedge clk);
        check("latency_edge3", {31'd0, r_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic aux_convert(input logic [31:0] in32, input logic [7:0] in8,
                               input logic [32:0] e32, input logic [32:0] e8);
        u32_data = in32;
        u8_data  = in8;
        a_valid  = 1'b1;
        @(negedge clk);
        check("u32_in_ready", {31'd0, u32_ready}, 32'd1);
        check("u8_in_ready", {31'd0, u8_ready}, 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("u32_valid", {31'd0, u32_rvalid}, 32'd1);
        check("u32_data", u32_res, e32[31:0]);
        check("u8_valid", {31'd0, u8_rvalid}, 32'd1);
        check("u8_data", u8_res, e8[31:0]);
`ifdef ITOF_INEXACT_FLAG_EN
        check("u32_inexact", {31'd0, u32_user}, {31'd0, e32[32]});
        check("u8_inexact", {31'd0, u8_user}, {31'd0, e8[32]});
`endif
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DIR_IN [12] = '{
        32'd1, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd16777217,
        32'd16777219, 32'd16777216, 32'd5, 32'hFFFF_FFFE, 32'h00FF_FFFF, 32'd16777218
    };
    localparam logic [32:0] DIR_EXP [12] = '{
        {1'b0, 32'h3F80_0000}, {1'b0, 32'hBF80_0000}, {1'b0, 32'h0000_0000},
        {1'b1, 32'h4F00_0000}, {1'b0, 32'hCF00_0000}, {1'b1, 32'h4B80_0000},
        {1'b1, 32'h4B80_0002}, {1'b0, 32'h4B80_0000}, {1'b0, 32'h40A0_0000},
        {1'b0, 32'hC000_0000}, {1'b0, 32'h4B7F_FFFF}, {1'b0, 32'h4B80_0001}
    };
    localparam logic [31:0] AUX32_IN [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'd0};
    localparam logic [7:0]  AUX8_IN  [4] = '{8'hFF, 8'h80, 8'h01, 8'h00};
    localparam logic [32:0] AUX32_EXP [4] = '{
        {1'b1, 32'h4F80_0000}, {1'b0, 32'h4F00_0000}, {1'b0, 32'h3F80_0000}, {1'b0, 32'h0000_0000}
    };
    localparam logic [32:0] AUX8_EXP [4] = '{
        {1'b0, 32'h437F_0000}, {1'b0, 32'h4300_0000}, {1'b0, 32'h3F80_0000}, {1'b0, 32'h0000_0000}
    };
    localparam logic [31:0] BP_IN [6] = '{
        32'd7, 32'hFFFF_FFF9, 32'd100, 32'h7FFF_FFFF, 32'd16777219, 32'hFEFF_FFFF
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x;
        areset   = 1'b1;
        s_valid  = 1'b0;
        s_data   = 32'd0;
        r_ready  = 1'b1;
        a_valid  = 1'b0;
        u32_data = 32'd0;
        u8_data  = 8'd0;
        a_rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'd0, r_valid}, 32'd0);
        check("reset_out_data", r_data, 32'd0);
        check("reset_in_ready", {31'd0, s_ready}, 32'd0);
`ifdef ITOF_INEXACT_FLAG_EN
        check("reset_out_user", {31'd0, r_user}, 32'd0);
`endif
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) convert_one(DIR_IN[i], DIR_EXP[i]);

        for (int i = 0; i < 4; i++) aux_convert(AUX32_IN[i], AUX8_IN[i], AUX32_EXP[i], AUX8_EXP[i]);

        // Backpressure: downstream stalls for 10 cycles while six items are offered.
        r_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(BP_IN[i], ref_conv(BP_IN[i]));
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", {31'd0, s_ready}, 32'd0);
                check("bp_out_valid_held", {31'd0, r_valid}, 32'd1);
                @(posedge clk);
                #1;
                r_ready = 1'b1;
            end
        join
        drain();

        // Random downstream readiness against the reference model.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    x = $urandom() >> $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) x = ~x + 32'd1;
                    send(x, ref_conv(x));
                end
                rand_done = 1'b1;
            end
            begin
                for (int c = 0; c < 3000 && !(rand_done && exp_q.size() == 0); c++) begin
                    @(posedge clk);
                    #1;
                    r_ready = ($urandom_range(0, 1) == 1);
                end
                r_ready = 1'b1;
            end
        join
        drain();

        // Reset with three items in flight.
        r_ready = 1'b1;
        send(32'd3, {1'b0, 32'h4040_0000});
        send(32'd4, {1'b0, 32'h4080_0000});
        send(32'd6, {1'b0, 32'h40C0_0000});
        areset = 1'b1;
        @(negedge clk);
        check("rst_in_ready_low", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_out_valid_low", {31'd0, r_valid}, 32'd0);
        check("rst_in_ready_high", {31'd0, s_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_stale", {31'd0, r_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        convert_one(32'd5, {1'b0, 32'h40A0_0000});
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
